store_unit: RTL

Store path from the processor datapath into the 32-bit `Memoria32` data memory. It accepts one 64-bit store request (byte, half, word or double) per handshake and converts it into one or two 32-bit memory writes. Byte and half stores use a read-modify-write through the memory read port. It is the write-side counterpart of the processor's instruction-fetch read path, and it sits between the datapath/ControlUnit and the memory's `waddress`/`Datain`/`Wr` port.

---
 rtl/store_unit_if.sv | 41 ++++
 rtl/store_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit_if.sv
// ---------------------------------------------------------------------------
// store_unit_if
//   Signal bundle between the processor datapath / data memory and the
//   store_unit write path.
//
//   Request side : Req, Size, Addr, Data (in to the unit); Busy, Done,
//                  Misalign (out of the unit).
//   Memory side  : MemRaddress, MemWaddress, MemDatain, MemWr (out of the
//                  unit); MemDataout (memory read data, in to the unit).
//
//   Modports
//     master : the environment (datapath + Memoria32) that issues stores
//              and provides memory read data.
//     slave  : the store_unit itself.
// ---------------------------------------------------------------------------
interface store_unit_if;

  logic        Req;
  logic [1:0]  Size;
  logic [63:0] Addr;
  logic [63:0] Data;
  logic        Busy;
  logic        Done;
  logic        Misalign;
  logic [31:0] MemRaddress;
  logic [31:0] MemDataout;
  logic [31:0] MemWaddress;
  logic [31:0] MemDatain;
  logic        MemWr;

  modport master (
    output Req, Size, Addr, Data, MemDataout,
    input  Busy, Done, Misalign, MemRaddress, MemWaddress, MemDatain, MemWr
  );

  modport slave (
    input  Req, Size, Addr, Data, MemDataout,
    output Busy, Done, Misalign, MemRaddress, MemWaddress, MemDatain, MemWr
  );

endinterface

// File: rtl/store_unit.sv
// ---------------------------------------------------------------------------
// store_unit
//   Store path from the processor datapath into the 32-bit Memoria32 data
//   memory. Each accepted 64-bit store request (byte, half, word, double)
//   becomes one or two 32-bit memory writes. Byte and half stores merge the
//   new lanes into the existing word via a read-modify-write on the memory
//   read port.
//
// Parameters
//   RD_LAT : memory read latency in cycles (1..4), MemRaddress -> MemDataout.
//
// Ports
//   Clk    : clock, rising edge.
//   Reset  : asynchronous, active-low reset.
//   bus    : store_unit_if.slave
//            Req/Size/Addr/Data  store request (accepted only while idle)
//            Busy                unit occupied
//            Done                one-cycle completion pulse (incl. error)
//            Misalign            one-cycle pulse for a rejected store
//            MemRaddress/MemDataout        read port (RMW for byte/half)
//            MemWaddress/MemDatain/MemWr   write port
//
// Build option
//   STORE_ALIGN_CHECK_EN : when defined, misaligned stores are rejected via
//   the ERR state (Done + Misalign, no write). When undefined, the low
//   address bits are masked to natural alignment and the store proceeds;
//   Misalign stays 0.
// ---------------------------------------------------------------------------
module store_unit #(
  parameter int RD_LAT = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  store_unit_if.slave  bus
);

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  // WAIT counts down from RD_LAT-1 to 0; the read word is captured at the
  // edge that leaves WAIT with the counter at 0.
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR_LO,
    WR_HI
`ifdef STORE_ALIGN_CHECK_EN
    , ERR
`endif
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [63:0] data_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  wait_cnt_reg;

  // -------------------------------------------------------------------------
  // Request decode: natural-alignment mask for the incoming size.
  // -------------------------------------------------------------------------
  logic [31:0] align_mask;
  logic [31:0] addr_aligned;

  always_comb begin
    align_mask = 32'h0;
    case (bus.Size)
      SZ_HALF:   align_mask = 32'h1;
      SZ_WORD:   align_mask = 32'h3;
      SZ_DOUBLE: align_mask = 32'h7;
      default:   align_mask = 32'h0;
    endcase
    addr_aligned = bus.Addr[31:0] & ~align_mask;
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |(bus.Addr[31:0] & align_mask);
`endif

  // Only the low 32 address bits reach the 32-bit memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.Addr[63:32];

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.Req) begin
`ifdef STORE_ALIGN_CHECK_EN
          if (misaligned) state_next = ERR;
          else
`endif
          if (!bus.Size[1]) state_next = RD;     // byte/half: read-modify-write
          else              state_next = WR_LO;  // word/double: direct write
        end
      end
      RD:    state_next = WAIT;
      WAIT:  if (wait_cnt_reg == 2'd0) state_next = WR_LO;
      WR_LO: state_next = (size_reg == SZ_DOUBLE) ? WR_HI : IDLE;
      WR_HI: state_next = IDLE;
`ifdef STORE_ALIGN_CHECK_EN
      ERR:   state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      size_reg     <= SZ_BYTE;
      addr_reg     <= 32'h0;
      data_reg     <= 64'h0;
      rdata_reg    <= 32'h0;
      wait_cnt_reg <= 2'd0;
    end else begin
      if (state_reg == IDLE && bus.Req) begin
        size_reg <= bus.Size;
        addr_reg <= addr_aligned;
        data_reg <= bus.Data;
      end

      if (state_reg == RD) begin
        wait_cnt_reg <= WAIT_INIT;
      end else if (state_reg == WAIT && wait_cnt_reg != 2'd0) begin
        wait_cnt_reg <= wait_cnt_reg - 2'd1;
      end

      if (state_reg == WAIT && wait_cnt_reg == 2'd0) begin
        rdata_reg <= bus.MemDataout;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lane merge for byte/half stores. Lanes are little-endian (lane 0 = 7:0).
  // A half store selects lane pair addr[1]; its lane gi takes Data byte
  // gi%2. A byte store selects lane addr[1:0] and always takes Data[7:0].
  // -------------------------------------------------------------------------
  logic [31:0] merged;
  logic [3:0]  lane_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam int         SRC  = (gi % 2) * 8;

      assign lane_sel[gi] = (size_reg == SZ_HALF) ? (addr_reg[1] == LANE[1])
                                                  : (addr_reg[1:0] == LANE);

      assign merged[gi*8 +: 8] =
          !lane_sel[gi]          ? rdata_reg[gi*8 +: 8] :
          (size_reg == SZ_HALF)  ? data_reg[SRC +: 8]   :
                                   data_reg[7:0];
    end
  endgenerate

  logic [31:0] word_addr;
  assign word_addr = {addr_reg[31:2], 2'b00};

  // -------------------------------------------------------------------------
  // Outputs: purely a function of the state register so that they all drop
  // together the moment Reset forces IDLE.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.Busy        = 1'b0;
    bus.Done        = 1'b0;
    bus.Misalign    = 1'b0;
    bus.MemRaddress = 32'h0;
    bus.MemWaddress = 32'h0;
    bus.MemDatain   = 32'h0;
    bus.MemWr       = 1'b0;
    case (state_reg)
      IDLE: begin
      end
      RD, WAIT: begin
        bus.Busy        = 1'b1;
        bus.MemRaddress = word_addr;
      end
      WR_LO: begin
        bus.Busy        = 1'b1;
        bus.MemWr       = 1'b1;
        bus.MemWaddress = word_addr;
        bus.MemDatain   = size_reg[1] ? data_reg[31:0] : merged;
        bus.Done        = (size_reg != SZ_DOUBLE);
      end
      WR_HI: begin
        bus.Busy        = 1'b1;
        bus.MemWr       = 1'b1;
        bus.MemWaddress = word_addr + 32'd4;  // wraps modulo 2^32
        bus.MemDatain   = data_reg[63:32];
        bus.Done        = 1'b1;
      end
`ifdef STORE_ALIGN_CHECK_EN
      ERR: begin
        bus.Busy        = 1'b1;
        bus.Done        = 1'b1;
        bus.Misalign    = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule
